alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Parametrised successor to the single-cycle ALU control decoder. Decodes ALUOp plus the R-type opcode field into a 4-bit ALU operation code, registered behind a valid/ready handshake. Adds EOR and a multi-cycle MUL, executed by an internal radix-2 shift-add engine. An illegal-opcode flag is also produced. Sits between the main control/ID stage and the EX stage, which stalls on in_ready.

Parameters:
WIDTH, 64, operand and product width in bits (product truncated to WIDTH)
OPC_W, 11, width of the opcode field (instruction[31:21])
ILLEGAL_CODE, 4'b1111, operation_code driven for unrecognised R-type opcodes
EARLY_EXIT, 0, 1 = MUL finishes as soon as the remaining multiplier bits are all zero

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
alu_op  input  2  {ALUOp1, ALUOp0}
opcode  input  OPC_W  R-type opcode field
operand_a  input  WIDTH  multiplicand (used only for MUL)
operand_b  input  WIDTH  multiplier (used only for MUL)
out_valid  output  1  result registers valid
out_ready  input  1  consumer accepts the result
operation_code  output  4  decoded ALU operation
mul_result  output  WIDTH  low WIDTH bits of a*b (valid for MUL only, else 0)
illegal  output  1  R-type opcode not in the map
busy  output  1  MUL engine iterating

Behaviour:
- Decode priority: alu_op==00 -> 0010. alu_op[0]==1 (01 or 11) -> 0111. alu_op==10 -> R-type map.
- R-type map: 10001011000 ADD -> 0010; 11001011000 SUB -> 0110; 10001010000 AND -> 0000; 10101010000 ORR -> 0001; 11001010000 EOR -> 0011; 10011011000 MUL -> 1000. Any other opcode -> ILLEGAL_CODE with illegal=1.
- Opcode match is exact. For OPC_W>11, the map compares the top 11 bits and requires the lower bits to be zero.
- States: IDLE, MUL, HOLD.
- Handshake: a request is accepted on a rising edge with in_valid && in_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- The output is consumed on an edge with out_valid && out_ready.
- Non-MUL request accepted at edge k: at edge k the block registers operation_code/illegal, sets mul_result=0, enters HOLD. out_valid=1 after edge k (1-cycle latency).
- MUL request accepted at edge k:
  - latch a, b; acc=0; count=0; enter MUL; busy=1; operation_code=1000.
  - Each MUL edge: if b[0], acc+=a (mod 2^WIDTH); a<<=1; b>>=1; count++.
  - After WIDTH iterations (edge k+WIDTH), go to HOLD with mul_result=acc and out_valid=1.
  - With EARLY_EXIT=1, move to HOLD on the first MUL edge where the post-shift b==0. A zero multiplier therefore finishes after 1 iteration.
- In MUL, in_ready=0. in_valid is ignored (not queued).
- HOLD: outputs are stable until out_ready=1.
  - out_ready=1 and in_valid=1: the new request is accepted on the same edge (back-to-back, no bubble).
  - out_ready=1 and in_valid=0: return to IDLE, out_valid=0.
- out_ready while out_valid=0 has no effect.
- Reset (asynchronous, any state, including mid-MUL): state=IDLE, out_valid=0, busy=0, operation_code=0000, mul_result=0, illegal=0, internal acc/count cleared. The partial product is discarded.
- All outputs are registered. No combinational path from in_* to out_* except in_ready from out_ready in HOLD.

Test Plan:
- Reset mid-MUL (WIDTH=8, 3 cycles in): assert rst_n=0 -> all outputs 0 and in_ready=1 immediately. After release, a new ADD request decodes normally.
- Decode sweep, alu_op=10, opcodes ADD/SUB/AND/ORR/EOR -> operation_code 0010/0110/0000/0001/0011, illegal=0, out_valid one cycle after accept. Opcode 11111111111 -> 1111, illegal=1.
- Priority: alu_op=00 -> 0010; 01 and 11 with opcode=SUB -> 0111; never illegal.
- MUL WIDTH=8, EARLY_EXIT=0: a=13, b=11 -> out_valid 8 cycles after accept, mul_result=143, busy high those 8 cycles. a=200, b=3 -> mul_result=88 (600 mod 256).
- MUL WIDTH=8, EARLY_EXIT=1: a=5, b=2 -> mul_result=10 after 2 cycles; b=0 -> 0 after 1 cycle.
- Backpressure and back-to-back: out_ready=0 for 4 cycles holds outputs stable with in_ready=0. Raising out_ready with in_valid=1 (AND) accepts on the same edge, and AND's 0000 appears the next cycle with no idle gap.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder behind a valid/ready handshake, with a
// radix-2 shift-add engine for the multi-cycle MUL operation.
module alu_ctrl_seq #(
    parameter int         WIDTH        = 64,
    parameter int         OPC_W        = 11,
    parameter logic [3:0] ILLEGAL_CODE = 4'b1111,
    parameter bit         EARLY_EXIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       operation_code,
    output logic [WIDTH-1:0] mul_result,
    output logic             illegal,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [CW-1:0]    r_cnt;
    logic [10:0]      w_top;
    logic [OPC_W-1:0] w_low;
    logic [3:0]       w_rcode, w_code;
    logic             w_rill, w_rmul, w_ill, w_is_mul, w_accept, w_done;
    logic [WIDTH-1:0] w_acc_nxt, w_b_nxt;
    // Wider opcode fields match on the top 11 bits and demand zeros below.
    assign w_top = opcode[OPC_W-1 -: 11];
    assign w_low = opcode << 11;
    always_comb begin
        w_rcode = ILLEGAL_CODE;
        w_rill  = 1'b1;
        w_rmul  = 1'b0;
        if (w_low == '0)
            case (w_top)
                11'b10001011000: {w_rcode, w_rill} = {4'b0010, 1'b0};
                11'b11001011000: {w_rcode, w_rill} = {4'b0110, 1'b0};
                11'b10001010000: {w_rcode, w_rill} = {4'b0000, 1'b0};
                11'b10101010000: {w_rcode, w_rill} = {4'b0001, 1'b0};
                11'b11001010000: {w_rcode, w_rill} = {4'b0011, 1'b0};
                11'b10011011000: {w_rcode, w_rill, w_rmul} = {4'b1000, 1'b0, 1'b1};
                default: ;
            endcase
    end
    assign w_code    = (alu_op == 2'b00) ? 4'b0010 : alu_op[0] ? 4'b0111 : w_rcode;
    assign w_ill     = (alu_op == 2'b10) && w_rill;
    assign w_is_mul  = (alu_op == 2'b10) && w_rmul;
    assign in_ready  = (r_state == IDLE) || (r_state == HOLD && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_acc_nxt = r_b[0] ? r_acc + r_a : r_acc;
    assign w_b_nxt   = r_b >> 1;
    assign w_done    = (r_cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && w_b_nxt == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            out_valid      <= 1'b0;
            busy           <= 1'b0;
            operation_code <= 4'b0000;
            mul_result     <= '0;
            illegal        <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
        end else if (r_state == MUL) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= w_b_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
                r_state    <= HOLD;
                busy       <= 1'b0;
                out_valid  <= 1'b1;
                mul_result <= w_acc_nxt;
            end
        end else if (w_accept) begin
            operation_code <= w_code;
            illegal        <= w_ill;
            mul_result     <= '0;
            if (w_is_mul) begin
                r_state   <= MUL;
                busy      <= 1'b1;
                out_valid <= 1'b0;
                r_a       <= operand_a;
                r_b       <= operand_b;
                r_acc     <= '0;
                r_cnt     <= '0;
            end else begin
                r_state   <= HOLD;
                out_valid <= 1'b1;
            end
        end else if (r_state == HOLD && out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench driving two 8-bit alu_ctrl_seq instances,
// u0 with full-length MUL and u1 with early exit.
`timescale 1ns/1ps
module tb_alu_ctrl_seq;
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_EOR = 11'b11001010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    localparam logic [10:0] TBL [6] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MUL};
    localparam logic [3:0]  COD [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1000};

    typedef struct packed {
        logic [3:0] code;
        logic       ill;
        logic [7:0] res;
        int         acc;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv [2];
    logic       ir [2];
    logic [1:0] aop [2];
    logic [10:0] opc [2];
    logic [7:0] opa [2];
    logic [7:0] opb [2];
    logic       ov [2];
    logic       ordy [2];
    logic [3:0] oc [2];
    logic [7:0] mr [2];
    logic       ill [2];
    logic       bsy [2];
    logic       frc [2];
    logic       fval [2];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   bcnt [2] = '{0, 0};
    bit   fresh [2] = '{1'b1, 1'b1};
    exp_t q0 [$];
    exp_t q1 [$];

    alu_ctrl_seq #(.WIDTH(8), .OPC_W(11), .ILLEGAL_CODE(4'b1111), .EARLY_EXIT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .alu_op(aop[0]),
        .opcode(opc[0]), .operand_a(opa[0]), .operand_b(opb[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .operation_code(oc[0]), .mul_result(mr[0]), .illegal(ill[0]),
        .busy(bsy[0]));
    alu_ctrl_seq #(.WIDTH(8), .OPC_W(11), .ILLEGAL_CODE(4'b1111), .EARLY_EXIT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .alu_op(aop[1]),
        .opcode(opc[1]), .operand_a(opa[1]), .operand_b(opb[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .operation_code(oc[1]), .mul_result(mr[1]), .illegal(ill[1]),
        .busy(bsy[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random backpressure unless the directed sequence pins out_ready.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) ordy[i] = frc[i] ? fval[i] : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(string nm, int i, int act, int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s[u%0d] @cyc %0d: got %0h expected %0h", nm, i, cyc, act, want);
        end
    endtask

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpush(int i, exp_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic void qpop(int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endfunction

    // Reference: decode table lookup, product mod 256, iteration count from the multiplier's bit length.
    function automatic exp_t model(int i, logic [1:0] op, logic [10:0] oc_v, logic [7:0] av, logic [7:0] bv);
        exp_t e;
        int   n;
        int   p;
        e = '0;
        if (op == 2'b00) e.code = 4'b0010;
        else if (op[0]) e.code = 4'b0111;
        else begin
            e.code = 4'b1111;
            e.ill  = 1'b1;
            for (int j = 0; j < 6; j++)
                if (oc_v == TBL[j]) begin
                    e.code = COD[j];
                    e.ill  = 1'b0;
                end
            if (oc_v == OP_MUL) begin
                p = int'(av) * int'(bv);
                e.res = 8'(p % 256);
                n = 0;
                for (int v = int'(bv); v != 0; v = v >> 1) n++;
                e.lat = (i == 0) ? 8 : ((n == 0) ? 1 : n);
            end
        end
        return e;
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(int i, logic [1:0] op, logic [10:0] oc_v, logic [7:0] av, logic [7:0] bv);
        exp_t e;
        int   w;
        iv[i] = 1'b1; aop[i] = op; opc[i] = oc_v; opa[i] = av; opb[i] = bv;
        w = 0;
        @(negedge clk);
        while (!ir[i] && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ir[i]) begin
            tests++; fails++;
            $display("FAIL accept_timeout[u%0d]: in_ready stayed 0, expected 1 within 100 cycles", i);
            iv[i] = 1'b0;
            return;
        end
        e = model(i, op, oc_v, av, bv);
        e.acc = cyc + 1;
        qpush(i, e);
        @(posedge clk);
        #1 iv[i] = 1'b0;
    endtask

    task automatic mon(int i);
        exp_t e;
        if (!rst_n) return;
        if (bsy[i]) bcnt[i]++;
        if (!ov[i]) return;
        if (qsize(i) == 0) begin
            tests++; fails++;
            $display("FAIL spurious_out[u%0d]: out_valid=1, expected 0 (nothing outstanding)", i);
            return;
        end
        e = qfront(i);
        if (fresh[i]) begin
            chk("latency", i, cyc - e.acc, e.lat);
            chk("busy_cycles", i, bcnt[i], e.lat);
            bcnt[i] = 0;
            fresh[i] = 1'b0;
        end
        chk("operation_code", i, int'(oc[i]), int'(e.code));
        chk("illegal", i, int'(ill[i]), int'(e.ill));
        chk("mul_result", i, int'(mr[i]), int'(e.res));
        chk("busy_when_valid", i, int'(bsy[i]), 0);
        if (ordy[i]) begin
            qpop(i);
            fresh[i] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic chk_reset(int i);
        chk("rst_out_valid", i, int'(ov[i]), 0);
        chk("rst_busy", i, int'(bsy[i]), 0);
        chk("rst_code", i, int'(oc[i]), 0);
        chk("rst_mul_result", i, int'(mr[i]), 0);
        chk("rst_illegal", i, int'(ill[i]), 0);
        chk("rst_in_ready", i, int'(ir[i]), 1);
    endtask

    task automatic rnd(int i);
        logic [1:0]  op;
        logic [10:0] o;
        int          r;
        repeat (40) begin
            op = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 6);
            o  = (r < 6) ? TBL[r] : 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 2) == 0) o = OP_MUL;
            send(i, op, o, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(int i);
        int w;
        w = 0;
        while (qsize(i) != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (qsize(i) != 0) begin
            tests++; fails++;
            $display("FAIL drain[u%0d]: %0d results outstanding, expected 0", i, qsize(i));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; aop[i] = 2'b00; opc[i] = '0; opa[i] = '0; opb[i] = '0;
            ordy[i] = 1'b0; frc[i] = 1'b0; fval[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Abort a multiply part-way through with an asynchronous reset.
        send(0, 2'b10, OP_MUL, 8'd13, 8'd11);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset(0);
        q0.delete();
        bcnt[0] = 0;
        fresh[0] = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 2'b10, OP_ADD, 8'd1, 8'd2);
        for (int j = 0; j < 5; j++) send(0, 2'b10, TBL[j], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        send(0, 2'b10, 11'b11111111111, 8'd0, 8'd0);
        send(0, 2'b00, OP_SUB, 8'd0, 8'd0);
        send(0, 2'b01, OP_SUB, 8'd0, 8'd0);
        send(0, 2'b11, OP_SUB, 8'd0, 8'd0);
        send(0, 2'b10, OP_MUL, 8'd13, 8'd11);
        send(0, 2'b10, OP_MUL, 8'd200, 8'd3);
        send(1, 2'b10, OP_MUL, 8'd5, 8'd2);
        send(1, 2'b10, OP_MUL, 8'd5, 8'd0);
        send(1, 2'b10, OP_MUL, 8'd200, 8'd3);
        drain(0);
        drain(1);
        // Backpressure, then release together with a new request.
        frc[0] = 1'b1;
        fval[0] = 1'b0;
        @(posedge clk);
        #1;
        send(0, 2'b10, OP_ORR, 8'd0, 8'd0);
        repeat (4) begin
            @(negedge clk);
            chk("hold_out_valid", 0, int'(ov[0]), 1);
            chk("hold_in_ready", 0, int'(ir[0]), 0);
            chk("hold_code", 0, int'(oc[0]), 1);
        end
        @(posedge clk);
        #1 fval[0] = 1'b1;
        send(0, 2'b10, OP_AND, 8'd0, 8'd0);
        chk("b2b_out_valid", 0, int'(ov[0]), 1);
        chk("b2b_code", 0, int'(oc[0]), 0);
        frc[0] = 1'b0;
        fork
            rnd(0);
            rnd(1);
        join
        drain(0);
        drain(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
